// File: rtl/ens_layer_sequencer_pkg.sv
// Shared types and constant tables for the ensemble layer sequencer.
// Holds the FSM state enum, fan-in wiring and default neuron LUT contents.
package ens_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_DONE
  } seq_state_e;

  localparam int N_NEURONS_DEF = 8;
  localparam int IN_ACTS_DEF   = 16;
  localparam int ACT_BITS_DEF  = 2;
  localparam int FANIN_DEF     = 3;

  // Element 0 of each row lands in the address LSBs.
  localparam int FANIN_IDX [N_NEURONS_DEF][FANIN_DEF] = '{
    '{0, 1, 2}, '{1, 2, 3}, '{2, 3, 4}, '{3, 4, 5},
    '{4, 5, 6}, '{5, 6, 7}, '{6, 7, 8}, '{7, 8, 9}
  };

  function automatic int fanin_idx(int n, int k, int in_acts);
    return (n + k) % in_acts;
  endfunction

  function automatic int lut_entry(int addr, int act_bits, int fanin);
    int s;
    int mx;
    s  = 0;
    mx = (1 << act_bits) - 1;
    for (int k = 0; k < fanin; k++) begin
      s += (addr >> (k * act_bits)) & mx;
    end
    return mx - ((s > mx) ? mx : s);
  endfunction

  function automatic logic [127:0] build_lut_init();
    logic [127:0] t;
    t = '0;
    for (int a = 0; a < 64; a++) begin
      t[a*2 +: 2] = 2'(lut_entry(a, ACT_BITS_DEF, FANIN_DEF));
    end
    return t;
  endfunction

  localparam logic [127:0] LUT_INIT = build_lut_init();

endpackage

// File: rtl/ens_layer_sequencer_if.sv
// Input/output valid-ready bundle of the layer sequencer.
// slave = sequencer side, master = producer/consumer side.
interface ens_layer_sequencer_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ens_layer_sequencer_lut.sv
// ens_lut_bank: per-neuron distributed ROM, (neuron, address) -> activation.
// Contents are constant and fold into plain logic.
module ens_lut_bank
  import ens_seq_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int ACT_BITS  = 2,
  parameter int FANIN     = 3,
  parameter int IDX_W     = 3,
  localparam int AW       = FANIN * ACT_BITS,
  localparam int DEPTH    = 1 << AW
) (
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [AW-1:0]       addr_i,
  output logic [ACT_BITS-1:0] data_o
);

  logic [ACT_BITS-1:0] rom [N_NEURONS][DEPTH];

  for (genvar gn = 0; gn < N_NEURONS; gn++) begin : g_n
    for (genvar ga = 0; ga < DEPTH; ga++) begin : g_a
      assign rom[gn][ga] = ACT_BITS'(lut_entry(ga, ACT_BITS, FANIN));
    end
  end

  assign data_o = rom[idx_i][addr_i];

endmodule

// File: rtl/ens_layer_sequencer.sv
// Evaluates one neuron per cycle over a captured input vector.
// Optional ENS_SEQ_FRAME_CNT_EN adds a saturating handshake counter.
module ens_layer_sequencer
  import ens_seq_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int IN_ACTS   = 16,
  parameter int ACT_BITS  = 2,
  parameter int FANIN     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  ens_layer_sequencer_if.slave bus,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int AW    = FANIN * ACT_BITS;
  localparam int IW    = IN_ACTS * ACT_BITS;
  localparam int OW    = N_NEURONS * ACT_BITS;

  seq_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IW-1:0] in_q, in_d;
  logic [OW-1:0] out_q, out_d;
  logic ov_q, ov_d;

  logic [AW-1:0] addr;
  logic [ACT_BITS-1:0] lut_out;
  logic last, hs;

  assign last = (idx_q == IDX_W'(N_NEURONS - 1));
  assign hs   = ov_q && bus.out_ready;

  always_comb begin
    addr = '0;
    for (int k = 0; k < FANIN; k++) begin
      addr[k*ACT_BITS +: ACT_BITS] =
        in_q[fanin_idx(int'(idx_q), k, IN_ACTS)*ACT_BITS +: ACT_BITS];
    end
  end

  ens_lut_bank #(
    .N_NEURONS(N_NEURONS),
    .ACT_BITS (ACT_BITS),
    .FANIN    (FANIN),
    .IDX_W    (IDX_W)
  ) u_lut (
    .idx_i (idx_q),
    .addr_i(addr),
    .data_o(lut_out)
  );

  // out_valid trails DONE entry by one cycle so the last slot has settled.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    in_d    = in_q;
    out_d   = out_q;
    ov_d    = ov_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          in_d    = bus.in_data;
          idx_d   = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        out_d[int'(idx_q)*ACT_BITS +: ACT_BITS] = lut_out;
        idx_d = idx_q + 1'b1;
        if (last) begin
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ov_d = 1'b1;
        if (hs) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      in_q    <= in_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = out_q;
  assign busy          = (state_q != S_IDLE);

`ifdef ENS_SEQ_FRAME_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (hs && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign frame_cnt = cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
